// File: rtl/pwm_pkg.sv
// Shared types and default timing for the PWM bank.
// Mode encoding is shared by the write bus, the channel registers and the bench.
package pwm_pkg;
    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        RAMP   = 2'd2,
        RSVD   = 2'd3
    } pwm_mode_t;

    localparam int unsigned DEF_PERIOD = 10000;
    localparam int unsigned DEF_STEP   = 100;
endpackage

// File: rtl/pwm_if.sv
// Write port and PWM status bundle between a controller and the PWM bank.
// master drives channel writes and observes outputs; slave is the bank side.
interface pwm_if
    import pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 14
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    pwm_mode_t        wr_mode;
    logic [CNT_W-1:0] wr_duty;
    logic [N_CH-1:0]  pwm_out;
    logic             period_start;
    logic [N_CH-1:0]  ramp_busy;

    modport master (
        output wr_en, wr_ch, wr_mode, wr_duty,
        input  pwm_out, period_start, ramp_busy
    );

    modport slave (
        input  wr_en, wr_ch, wr_mode, wr_duty,
        output pwm_out, period_start, ramp_busy
    );
endinterface

// File: rtl/pwm_chan.sv
// One PWM channel: shadow/active mode and duty, per-period ramp step, output compare.
// Latency: shadow at next edge, active at the period boundary, pwm one cycle after compare.
// Backpressure: none, every write strobe is accepted.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int               CNT_W = 14,
    parameter logic [CNT_W-1:0] STEP  = CNT_W'(DEF_STEP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  pwm_mode_t        wr_mode,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic [CNT_W-1:0] cnt,
    input  logic             boundary,
    output logic             pwm,
    output logic             busy
);
    pwm_mode_t        mode, mode_a, eff_mode;
    logic [CNT_W-1:0] target, duty_a, eff_target, diff, step, duty_nxt;

    // A write landing in the boundary cycle bypasses the shadow so it commits at once.
    always_comb begin
        eff_mode   = sel ? wr_mode : mode;
        eff_target = sel ? wr_duty : target;
        diff       = (eff_target >= duty_a) ? (eff_target - duty_a) : (duty_a - eff_target);
        step       = (diff < STEP) ? diff : STEP;
        duty_nxt   = '0;
        case (eff_mode)
            DIRECT:  duty_nxt = eff_target;
            RAMP:    duty_nxt = (eff_target >= duty_a) ? (duty_a + step) : (duty_a - step);
            default: duty_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= OFF;
            target <= '0;
            mode_a <= OFF;
            duty_a <= '0;
            pwm    <= 1'b0;
        end else begin
            if (sel) begin
                mode   <= wr_mode;
                target <= wr_duty;
            end
            if (boundary) begin
                mode_a <= eff_mode;
                duty_a <= duty_nxt;
            end
            pwm <= (mode_a != OFF) && (cnt < duty_a);
        end
    end

    assign busy = (mode_a == RAMP) && (duty_a != target);
endmodule

// File: rtl/pwm_bank.sv
// Bank of N_CH PWM channels sharing one period counter and period_start pulse.
// Latency: outputs registered one cycle after the compare; period_start aligned to first bit.
// Backpressure: none, one write accepted per strobe cycle.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int               N_CH   = 4,
    parameter int               CNT_W  = 14,
    parameter logic [CNT_W-1:0] PERIOD = CNT_W'(DEF_PERIOD),
    parameter logic [CNT_W-1:0] STEP   = CNT_W'(DEF_STEP)
) (
    input  logic  clk,
    input  logic  rst,
    pwm_if.slave  bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CNT_W-1:0] cnt;
    logic             boundary;
    logic             period_start_q;
    logic [N_CH-1:0]  pwm_bits;
    logic [N_CH-1:0]  busy_bits;

    assign boundary = (cnt == PERIOD - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt            <= boundary ? '0 : cnt + 1'b1;
            period_start_q <= (cnt == '0);
        end
    end

    // Out-of-range channel numbers match no instance and are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_chan #(
            .CNT_W (CNT_W),
            .STEP  (STEP)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .sel      (bus.wr_en && (bus.wr_ch == CH_W'(i))),
            .wr_mode  (bus.wr_mode),
            .wr_duty  (bus.wr_duty),
            .cnt      (cnt),
            .boundary (boundary),
            .pwm      (pwm_bits[i]),
            .busy     (busy_bits[i])
        );
    end

    assign bus.pwm_out      = pwm_bits;
    assign bus.period_start = period_start_q;
    assign bus.ramp_busy    = busy_bits;
endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: per-cycle comparison against a behavioural model plus
// per-period high-time tallies checked against hand-derived values.
module tb_pwm_bank;
    import pwm_pkg::*;

    localparam int N_CH   = 3;
    localparam int CNT_W  = 14;
    localparam int CH_W   = 2;
    localparam int PERIOD = 500;
    localparam int STEP   = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    pwm_bank #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .PERIOD (CNT_W'(PERIOD)),
        .STEP   (CNT_W'(STEP))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt;
    logic        m_ps;
    logic [N_CH-1:0] m_pwm;
    int          m_smode [N_CH];
    int          m_tgt   [N_CH];
    int          m_amode [N_CH];
    int          m_duty  [N_CH];

    function automatic bit hits(int c);
        return bus.wr_en && (int'(bus.wr_ch) == c);
    endfunction

    function automatic int eff_mode(int c);
        return hits(c) ? int'(bus.wr_mode) : m_smode[c];
    endfunction

    function automatic int eff_tgt(int c);
        return hits(c) ? int'(bus.wr_duty) : m_tgt[c];
    endfunction

    function automatic int next_duty(int mode, int tgt, int cur);
        case (mode)
            1: return tgt;
            2: begin
                if (tgt > cur) return (cur + STEP < tgt) ? cur + STEP : tgt;
                return (cur - STEP > tgt) ? cur - STEP : tgt;
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [N_CH-1:0] exp_busy();
        logic [N_CH-1:0] b;
        b = '0;
        for (int c = 0; c < N_CH; c++) b[c] = (m_amode[c] == 2) && (m_duty[c] != m_tgt[c]);
        return b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_ps  <= 1'b0;
            m_pwm <= '0;
            for (int c = 0; c < N_CH; c++) begin
                m_smode[c] <= 0; m_tgt[c] <= 0; m_amode[c] <= 0; m_duty[c] <= 0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                m_pwm[c] <= (m_amode[c] != 0) && (m_cnt < m_duty[c]);
                if (hits(c)) begin
                    m_smode[c] <= int'(bus.wr_mode);
                    m_tgt[c]   <= int'(bus.wr_duty);
                end
                if (m_cnt == PERIOD - 1) begin
                    m_amode[c] <= eff_mode(c);
                    m_duty[c]  <= next_duty(eff_mode(c), eff_tgt(c), m_duty[c]);
                end
            end
            m_ps  <= (m_cnt == 0);
            m_cnt <= (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("pwm_out", bus.pwm_out, m_pwm);
        chk("period_start", bus.period_start, m_ps);
        chk("ramp_busy", bus.ramp_busy, exp_busy());
    end

    // ---------------- per-period high-time tallies ----------------
    int hc [N_CH];
    int hist [N_CH][$];

    always @(negedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (bus.period_start) begin
                hist[c].push_back(hc[c]);
                hc[c] <= int'(bus.pwm_out[c]);
            end else begin
                hc[c] <= hc[c] + int'(bus.pwm_out[c]);
            end
        end
    end

    task automatic chk_hist(input string name, input int c, input int idx, input int exp);
        chk(name, (hist[c].size() > idx) ? hist[c][idx] : -1, exp);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int ch, input pwm_mode_t m, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = CH_W'(ch);
        bus.wr_mode = m;
        bus.wr_duty = CNT_W'(d);
        @(posedge clk); #2;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!bus.period_start && n < 2 * PERIOD);
        chk("ps_seen", bus.period_start, 1'b1);
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (m_cnt != target && n < 2 * PERIOD);
        if (m_cnt != target) begin
            $display("FAIL cnt_timeout: counter %0d never reached %0d", m_cnt, target);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
            $fatal(1);
        end
    endtask

    task automatic ps_interval(output int n);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!bus.period_start && n < 2 * PERIOD);
    endtask

    task automatic release_and_check(input string tag);
        int n;
        rst = 1'b0;
        @(posedge clk); #2;
        chk({tag, "_ps_first"}, bus.period_start, 1'b1);
        ps_interval(n);
        chk({tag, "_ps_period"}, n, PERIOD);
    endtask

    // ---------------- test sequence ----------------
    int gap, ch, md, dv;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_ch   = '0;
        bus.wr_mode = OFF;
        bus.wr_duty = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_pwm", bus.pwm_out, 3'b000);
        chk("rst_ps", bus.period_start, 1'b0);
        chk("rst_busy", bus.ramp_busy, 3'b000);
        release_and_check("por");

        // DIRECT duty, back-to-back writes: last write wins
        wr(0, DIRECT, 300);
        wr(0, DIRECT, 100);
        wr(1, DIRECT, 200);
        wait_ps(); wait_ps();
        hist[0].delete();
        wait_ps(); wait_ps();
        chk_hist("direct_100_a", 0, 0, 100);
        chk_hist("direct_100_b", 0, 1, 100);

        // write in the boundary cycle commits immediately
        wait_cnt(PERIOD - 1);
        hist[1].delete();
        wr(1, DIRECT, 400);
        wait_ps(); wait_ps();
        chk_hist("bnd_in_progress", 1, 0, 200);
        chk_hist("bnd_next", 1, 1, 400);

        // ramp 0 -> 350
        wait_cnt(PERIOD - 1);
        wr(2, RAMP, 350);
        chk("ramp_busy_on", bus.ramp_busy[2], 1'b1);
        hist[2].delete();
        repeat (5) wait_ps();
        chk_hist("ramp_w0", 2, 0, 0);
        chk_hist("ramp_w1", 2, 1, 100);
        chk_hist("ramp_w2", 2, 2, 200);
        chk_hist("ramp_w3", 2, 3, 300);
        chk_hist("ramp_w4", 2, 4, 350);
        chk("ramp_busy_off", bus.ramp_busy[2], 1'b0);

        // duty 0 then a duty beyond the period
        wr(0, DIRECT, 0);
        wait_ps(); wait_ps();
        hist[0].delete();
        wait_ps(); wait_ps();
        chk_hist("zero_a", 0, 0, 0);
        chk_hist("zero_b", 0, 1, 0);
        wr(0, DIRECT, 10000);
        wait_ps(); wait_ps();
        hist[0].delete();
        wait_ps(); wait_ps();
        chk_hist("full_a", 0, 0, PERIOD);
        chk_hist("full_b", 0, 1, PERIOD);

        // out-of-range channel, then OFF on an active channel
        wait_ps();
        wr(3, DIRECT, 250);
        wr(0, OFF, 0);
        hist[0].delete();
        hist[1].delete();
        wait_ps(); wait_ps();
        chk_hist("off_in_progress", 0, 0, PERIOD);
        chk_hist("off_next", 0, 1, 0);
        chk_hist("oor_ch1_a", 1, 0, 400);
        chk_hist("oor_ch1_b", 1, 1, 400);

        // randomized writes, checked by the model every cycle
        for (int k = 0; k < 40; k++) begin
            gap = $urandom_range(1, 300);
            ch  = $urandom_range(0, 3);
            md  = $urandom_range(0, 3);
            case ($urandom_range(0, 7))
                0:       dv = 0;
                1:       dv = 10000;
                default: dv = $urandom_range(0, 600);
            endcase
            repeat (gap) @(posedge clk);
            #2;
            wr(ch, pwm_mode_t'(md), dv);
        end

        // asynchronous reset mid-period with every channel driving high
        wr(0, DIRECT, 450);
        wr(1, DIRECT, 480);
        wr(2, DIRECT, 10000);
        wait_ps(); wait_ps();
        wait_cnt(321);
        chk("pre_rst_pwm", bus.pwm_out, 3'b111);
        rst = 1'b1;
        #1;
        chk("async_rst_pwm", bus.pwm_out, 3'b000);
        chk("async_rst_ps", bus.period_start, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        release_and_check("mid");
        chk("post_rst_pwm", bus.pwm_out, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
